// File: rtl/proc_pkg.sv
// Shared definitions for the proc_ctrl datapath sequencer: control-step
// encoding and instruction opcodes.
package proc_pkg;

   // Control step of the instruction sequencer; T0 is idle/fetch.
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_e;

   // Three-bit opcode field at the top of the instruction word.
   typedef enum logic [2:0] {
      OpMv   = 3'b000,
      OpMvi  = 3'b001,
      OpAdd  = 3'b010,
      OpSub  = 3'b011,
      OpMvnz = 3'b100
   } op_e;

endpackage

// File: rtl/proc_dec.sv
// Binary-to-one-hot decoder with enable; output is all zeros when disabled.
module proc_dec #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [W-1:0] sel_i,
   input  logic         en_i,
   output logic [N-1:0] onehot_o
);

   // Drive a single bit selected by sel_i when enabled.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control sequencer for a simple register/ALU datapath.
// Fetches an instruction on run in T0, then steps through T1..T3 issuing
// register load/drive enables. All outputs decode from state and IR only.
// Optional feature: define PROC_CTRL_MVNZ_EN to enable the mvnz instruction
// (conditional move on g_nz); otherwise opcode 100 is treated as undefined.
module proc_ctrl
   import proc_pkg::*;
#(
   parameter int unsigned NREG = 8,
   parameter int unsigned IRW  = 9
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            run,
   input  logic [IRW-1:0]  din,
   input  logic            g_nz,
   output logic [NREG-1:0] r_in,
   output logic [NREG-1:0] r_out,
   output logic            a_in,
   output logic            g_in,
   output logic            g_out,
   output logic            din_out,
   output logic            addsub,
   output logic            done,
   output logic            busy
);

   localparam int unsigned RW = $clog2(NREG);

   state_e         state_q, state_d;
   logic [IRW-1:0] ir_q, ir_d;

   op_e            op;
   logic [RW-1:0]  x_sel, y_sel;
   logic [NREG-1:0] x_oh, y_oh;

   // Instruction fields: op in the top three bits, then x, then y.
   assign op    = op_e'(ir_q[IRW-1 -: 3]);
   assign x_sel = ir_q[2*RW-1 -: RW];
   assign y_sel = ir_q[RW-1:0];

   assign busy = (state_q != T0);

`ifndef PROC_CTRL_MVNZ_EN
   // g_nz only matters for mvnz; keep it visibly consumed when that is absent.
   logic unused_g_nz;
   assign unused_g_nz = g_nz;
`endif

   // Decoders are gated by busy so nothing is driven while idle.
   proc_dec #(
      .N (NREG),
      .W (RW)
   ) u_dec_x (
      .sel_i    (x_sel),
      .en_i     (busy),
      .onehot_o (x_oh)
   );

   proc_dec #(
      .N (NREG),
      .W (RW)
   ) u_dec_y (
      .sel_i    (y_sel),
      .en_i     (busy),
      .onehot_o (y_oh)
   );

   // State and instruction register, asynchronously cleared.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state: fetch on run in T0; only add/sub continue past T1.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         T0: begin
            if (run) begin
               ir_d    = din;
               state_d = T1;
            end
         end
         T1: begin
            if (op == OpAdd || op == OpSub) begin
               state_d = T2;
            end else begin
               state_d = T0;
            end
         end
         T2: state_d = T3;
         T3: state_d = T0;
         default: state_d = T0;
      endcase
   end

   // Output decode: one bus driver per step at most.
   always_comb begin
      r_in    = '0;
      r_out   = '0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      g_out   = 1'b0;
      din_out = 1'b0;
      addsub  = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         T0: ;
         T1: begin
            case (op)
               OpMv: begin
                  r_out = y_oh;
                  r_in  = x_oh;
                  done  = 1'b1;
               end
               OpMvi: begin
                  din_out = 1'b1;
                  r_in    = x_oh;
                  done    = 1'b1;
               end
               OpAdd, OpSub: begin
                  r_out = x_oh;
                  a_in  = 1'b1;
               end
`ifdef PROC_CTRL_MVNZ_EN
               OpMvnz: begin
                  if (g_nz) begin
                     r_out = y_oh;
                     r_in  = x_oh;
                  end
                  done = 1'b1;
               end
`endif
               default: done = 1'b1;
            endcase
         end
         T2: begin
            r_out  = y_oh;
            g_in   = 1'b1;
            addsub = ir_q[IRW-3];
         end
         T3: begin
            g_out = 1'b1;
            r_in  = x_oh;
            done  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_proc_ctrl.sv
// Scoreboard bench for proc_ctrl: the driver pushes the expected per-step
// control words for each instruction; a negedge monitor pops and compares
// whenever the DUT is busy, and requires all-zero outputs while idle.
module tb_proc_ctrl;

   localparam int unsigned NREG = 8;
   localparam int unsigned IRW  = 9;

   logic            clk = 1'b0;
   logic            resetn;
   logic            run;
   logic [IRW-1:0]  din;
   logic            g_nz;
   logic [NREG-1:0] r_in, r_out;
   logic            a_in, g_in, g_out, din_out, addsub, done, busy;

   proc_ctrl #(
      .NREG (NREG),
      .IRW  (IRW)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .run     (run),
      .din     (din),
      .g_nz    (g_nz),
      .r_in    (r_in),
      .r_out   (r_out),
      .a_in    (a_in),
      .g_in    (g_in),
      .g_out   (g_out),
      .din_out (din_out),
      .addsub  (addsub),
      .done    (done),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NREG-1:0] r_in;
      logic [NREG-1:0] r_out;
      logic            a_in;
      logic            g_in;
      logic            g_out;
      logic            din_out;
      logic            addsub;
      logic            done;
      logic            busy;
   } ctrl_t;

   ctrl_t sb_q[$];
   int    checks   = 0;
   int    failures = 0;

   function automatic ctrl_t act_now();
      ctrl_t c;
      c.r_in    = r_in;
      c.r_out   = r_out;
      c.a_in    = a_in;
      c.g_in    = g_in;
      c.g_out   = g_out;
      c.din_out = din_out;
      c.addsub  = addsub;
      c.done    = done;
      c.busy    = busy;
      return c;
   endfunction

   // Reference: list of control words, one per busy cycle, from the
   // instruction semantics. Returns the number of steps queued.
   function automatic int model(input logic [IRW-1:0] instr, input logic gnz);
      int              opc, xi, yi;
      logic [NREG-1:0] one;
      ctrl_t           s;
      opc = int'(instr[8:6]);
      xi  = int'(instr[5:3]);
      yi  = int'(instr[2:0]);
      one = 1;
      s   = '0;
      s.busy = 1'b1;
      if (opc == 0) begin
         s.r_out = one << yi; s.r_in = one << xi; s.done = 1'b1;
         sb_q.push_back(s);
         return 1;
      end else if (opc == 1) begin
         s.din_out = 1'b1; s.r_in = one << xi; s.done = 1'b1;
         sb_q.push_back(s);
         return 1;
      end else if (opc == 2 || opc == 3) begin
         s.r_out = one << xi; s.a_in = 1'b1;
         sb_q.push_back(s);
         s = '0; s.busy = 1'b1;
         s.r_out = one << yi; s.g_in = 1'b1; s.addsub = (opc == 3);
         sb_q.push_back(s);
         s = '0; s.busy = 1'b1;
         s.g_out = 1'b1; s.r_in = one << xi; s.done = 1'b1;
         sb_q.push_back(s);
         return 3;
`ifdef PROC_CTRL_MVNZ_EN
      end else if (opc == 4) begin
         if (gnz) begin
            s.r_out = one << yi; s.r_in = one << xi;
         end
         s.done = 1'b1;
         sb_q.push_back(s);
         return 1;
`endif
      end else begin
         s.done = 1'b1;
         sb_q.push_back(s);
         return 1;
      end
   endfunction

   // Monitor: compare every cycle, away from the active edge.
   always @(negedge clk) begin
      ctrl_t act, exp;
      int    nd;
      act = act_now();
      nd  = int'(r_out != '0) + int'(g_out) + int'(din_out);
      checks++;
      if (nd > 1) begin
         failures++;
         $display("FAIL bus_excl: %0d drivers active, required at most 1 (t=%0t)", nd, $time);
      end
      if (busy) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_busy: got %b, required idle (t=%0t)", act, $time);
         end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
               failures++;
               $display("FAIL step: got %b required %b (t=%0t)", act, exp, $time);
            end
         end
      end else begin
         checks++;
         if (act !== '0) begin
            failures++;
            $display("FAIL idle: got %b required all zero (t=%0t)", act, $time);
         end
      end
   end

   // Issue one instruction, inject noise on din/run while busy, then
   // confirm every expected step was consumed by the time T0 is back.
   task automatic issue(input logic [IRW-1:0] instr, input logic gnz, input logic hold);
      int n;
      din  = instr;
      g_nz = gnz;
      run  = 1'b1;
      n    = model(instr, gnz);
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         din = IRW'($urandom);
         run = 1'($urandom);
         @(posedge clk); #1;
      end
      run = hold;
      din = IRW'($urandom);
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d steps left, required 0 (instr=%b)", sb_q.size(), instr);
         sb_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ctrl_t a;
      int    unused_n;
      resetn = 1'b0;
      run    = 1'b0;
      din    = '0;
      g_nz   = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      // Idle cycles with run low; monitor requires all zeros.
      repeat (5) @(posedge clk);
      #1;

      issue(9'b001_010_000, 1'b0, 1'b0);  // mvi R2
      issue(9'b010_011_101, 1'b0, 1'b0);  // add R3,R5
      issue(9'b011_001_001, 1'b0, 1'b0);  // sub R1,R1
      issue(9'b000_100_100, 1'b0, 1'b0);  // mv R4,R4
      issue(9'b111_010_011, 1'b0, 1'b0);  // undefined
      issue(9'b100_000_111, 1'b1, 1'b0);  // mvnz, g_nz=1
      issue(9'b100_000_111, 1'b0, 1'b0);  // mvnz, g_nz=0

      // Abort an add in T2 with an asynchronous reset.
      din      = 9'b010_110_001;
      g_nz     = 1'b0;
      run      = 1'b1;
      unused_n = model(din, 1'b0);
      @(posedge clk); #1;
      run = 1'b0;
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      a = act_now();
      checks++;
      if (a !== '0) begin
         failures++;
         $display("FAIL async_reset: got %b required all zero", a);
      end
      sb_q.delete();
      @(posedge clk);
      @(posedge clk); #1;
      resetn = 1'b1;
      issue(9'b010_110_001, 1'b0, 1'b0);  // fresh add after reset

      // run held high across done: next instruction after one T0 cycle.
      issue(9'b000_001_010, 1'b0, 1'b1);
      issue(9'b001_111_000, 1'b0, 1'b1);
      issue(9'b011_010_110, 1'b0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         issue(IRW'($urandom), 1'($urandom), 1'($urandom));
      end
      run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL final_drain: %0d steps left, required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
